seq_pattern_player: RTL

Parametrised successor to the game's fixed 20-bit random generator and 2-bit-to-one-hot converter. On `start` it draws a sequence of up to MAX_LEN symbols from a parametrised LFSR and stores it. It then plays the sequence on NUM_CH one-hot lamps with programmable on/off timing. It sits between the game FSM, which starts and checks rounds, and the lamp/VGA drivers, and exposes the stored sequence through a read port for answer checking.

---
 rtl/seq_pattern_player_pkg.sv | 32 +++
 rtl/seq_pattern_player_if.sv | 34 +++
 rtl/seq_pattern_player_lfsr_gen.sv | 34 +++
 rtl/seq_pattern_player.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_player_pkg.sv
// Shared types and constants for the sequence pattern player.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GEN      = 2'd1,
        SHOW_ON  = 2'd2,
        SHOW_OFF = 2'd3
    } state_e;

    // Ceiling log2; clog2(1) is 0, callers guard zero-width results.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Maximal-length Fibonacci tap masks (bit i set = x^(i+1) term) and seeds.
    localparam logic [15:0] TAPS_16 = 16'hB400;      // x^16+x^14+x^13+x^11+1
    localparam logic [19:0] TAPS_20 = 20'h90000;     // x^20+x^17+1
    localparam logic [31:0] TAPS_32 = 32'h80200003;  // x^32+x^22+x^2+x+1
    localparam logic [15:0] SEED_16 = 16'h001f;
    localparam logic [19:0] SEED_20 = 20'h0001f;
    localparam logic [31:0] SEED_32 = 32'h0000001f;

endpackage

// File: rtl/seq_pattern_player_if.sv
// Control/status bundle between the game FSM (master) and the player (slave).
interface seq_pattern_player_if #(
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = 10,
    parameter int LFSR_W  = 20
);
    import seq_pattern_pkg::*;

    localparam int CHW = clog2(NUM_CH);
    localparam int LW  = clog2(MAX_LEN + 1);

    logic              start;
    logic [LW-1:0]     length;
    logic              abort;
    logic              reseed;
    logic [LFSR_W-1:0] seed_in;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] lamp;
    logic [LW-1:0]     step_idx;
    logic [LW-1:0]     rd_idx;
    logic [CHW-1:0]    rd_sym;

    modport master (
        output start, length, abort, reseed, seed_in, rd_idx,
        input  busy, done, lamp, step_idx, rd_sym
    );

    modport slave (
        input  start, length, abort, reseed, seed_in, rd_idx,
        output busy, done, lamp, step_idx, rd_sym
    );

endinterface

// File: rtl/seq_pattern_player_lfsr_gen.sv
// Fibonacci LFSR shifting left; zero loads are replaced by SEED so it never locks up.
module lfsr_gen #(
    parameter int                LFSR_W = 20,
    parameter logic [LFSR_W-1:0] TAPS   = 20'h90000,
    parameter logic [LFSR_W-1:0] SEED   = 20'h0001f
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              advance,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Load has priority over advance; feedback is the parity of tapped bits.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load)
            lfsr_d = (load_val == '0) ? SEED : load_val;
        else if (advance)
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    end

    // State register, returns to SEED on reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) lfsr_q <= SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/seq_pattern_player.sv
// Draws a random symbol sequence into a buffer, then plays it on one-hot lamps.
module seq_pattern_player
    import seq_pattern_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                MAX_LEN   = 10,
    parameter int                LFSR_W    = 20,
    parameter logic [LFSR_W-1:0] TAPS      = TAPS_20,
    parameter logic [LFSR_W-1:0] SEED      = SEED_20,
    parameter int                TICK_DIV  = 833334,
    parameter int                ON_TICKS  = 3,
    parameter int                OFF_TICKS = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    seq_pattern_player_if.slave  bus
);

    localparam int CHW  = clog2(NUM_CH);
    localparam int LW   = clog2(MAX_LEN + 1);
    localparam int PW   = (clog2(TICK_DIV) > 0) ? clog2(TICK_DIV) : 1;
    localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW   = (clog2(TMAX) > 0) ? clog2(TMAX) : 1;

    localparam logic [LW-1:0] MAX_L      = LW'(MAX_LEN);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);

    state_e            state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     step_q, step_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [NUM_CH-1:0] lamp_q, lamp_d;
    logic              done_q, done_d;
    logic              busy_q;

    logic              advance, lfsr_load, buf_we, tick;
    logic [LW-1:0]     nxt_idx;
    logic [CHW-1:0]    sym, first_sym;
    logic [LFSR_W-1:0] lfsr;
    logic [CHW-1:0]    sym_buf_q [MAX_LEN];

    // Reseed only while idle; in the start cycle it lands before GEN's first draw.
    assign lfsr_load = (state_q == IDLE) && bus.reseed;

    lfsr_gen #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .advance  (advance),
        .load     (lfsr_load),
        .load_val (bus.seed_in),
        .q        (lfsr)
    );

    assign sym     = lfsr[CHW-1:0];
    assign tick    = (presc_q == PRESC_LAST);
    assign nxt_idx = idx_q + LW'(1);
    // For a one-symbol round buf[0] is written on the same edge SHOW_ON is entered.
    assign first_sym = (idx_q == '0) ? sym : sym_buf_q[0];

    // Next-state and output decode; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        step_d  = step_q;
        presc_d = presc_q;
        tcnt_d  = tcnt_q;
        lamp_d  = lamp_q;
        done_d  = 1'b0;
        advance = 1'b0;
        buf_we  = 1'b0;
        case (state_q)
            IDLE: begin
                lamp_d  = '0;
                idx_d   = '0;
                step_d  = '0;
                presc_d = '0;
                tcnt_d  = '0;
                if (bus.start && !bus.abort) begin
                    if (bus.length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = (bus.length > MAX_L) ? MAX_L : bus.length;
                        state_d = GEN;
                    end
                end
            end
            GEN: begin
                advance = 1'b1;
                buf_we  = 1'b1;
                idx_d   = nxt_idx;
                if (idx_q == len_q - LW'(1)) begin
                    state_d = SHOW_ON;
                    idx_d   = '0;
                    step_d  = '0;
                    presc_d = '0;
                    tcnt_d  = '0;
                    lamp_d  = NUM_CH'(1) << first_sym;
                end
            end
            SHOW_ON: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (tcnt_q == ON_LAST) begin
                        state_d = SHOW_OFF;
                        tcnt_d  = '0;
                        lamp_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            SHOW_OFF: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (tcnt_q == OFF_LAST) begin
                        tcnt_d = '0;
                        if (idx_q == len_q - LW'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            idx_d   = '0;
                            step_d  = '0;
                        end else begin
                            state_d = SHOW_ON;
                            idx_d   = nxt_idx;
                            step_d  = nxt_idx;
                            lamp_d  = NUM_CH'(1) << sym_buf_q[nxt_idx];
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            lamp_d  = '0;
            done_d  = 1'b0;
            idx_d   = '0;
            step_d  = '0;
            presc_d = '0;
            tcnt_d  = '0;
            advance = 1'b0;
            buf_we  = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            step_q  <= '0;
            presc_q <= '0;
            tcnt_q  <= '0;
            lamp_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            lamp_q  <= lamp_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Symbol buffer: no reset, contents only meaningful once written.
    always_ff @(posedge CLOCK_50) begin
        if (buf_we) sym_buf_q[idx_q] <= sym;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.lamp     = lamp_q;
    assign bus.step_idx = step_q;
    assign bus.rd_sym   = (bus.rd_idx < MAX_L) ? sym_buf_q[bus.rd_idx] : '0;

endmodule
